// File: rtl/dmem_sweep_if.sv
// dmem_sweep_if: access bus between the core load/store path and dmem_sweep.
// The core (or bench) drives the master side; the memory is the slave side.
interface dmem_sweep_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              Enable;
    logic              Write_en;
    logic [ADDR_W-1:0] Address_port;
    logic [DATA_W-1:0] Input_data;
    logic              Clear;
    logic [DATA_W-1:0] Output_data;
    logic              Valid;
    logic              Busy;

    modport master (
        output Enable, Write_en, Address_port, Input_data, Clear,
        input  Output_data, Valid, Busy
    );

    modport slave (
        input  Enable, Write_en, Address_port, Input_data, Clear,
        output Output_data, Valid, Busy
    );
endinterface

// File: rtl/dmem_sweep.sv
// dmem_sweep: parametrised single-port synchronous data memory with registered
// reads, a Valid strobe and a hardware initialisation sweep that writes
// INIT_VAL to every word after reset or on a Clear request.
// Optional build macro DMEM_OUTREG_EN adds an output register stage
// (read latency 2 instead of 1); that stage is flushed by reset and Clear.
module dmem_sweep #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    dmem_sweep_if.slave bus
);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rd;
    logic              w_in_range;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] r_data_p1;
    logic              r_vld_p1;

    // Address range decode: out-of-range writes drop, out-of-range reads return zero.
    assign w_in_range = ({1'b0, bus.Address_port} < DEPTH_L);

    // State register and sweep counter; reset restarts the sweep at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, memory write port and read request; Clear beats any access.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_we    = 1'b0;
        w_mem_addr  = bus.Address_port;
        w_mem_wdata = bus.Input_data;
        w_rd        = 1'b0;
        unique case (r_state)
            S_INIT: begin
                // Sweep owns the write port; user requests are ignored.
                w_mem_we    = 1'b1;
                w_mem_addr  = r_cnt;
                w_mem_wdata = INIT_VAL;
                if (r_cnt == LAST_A) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            S_RUN: begin
                if (bus.Clear) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                end else if (bus.Enable && bus.Write_en) begin
                    w_mem_we = w_in_range;
                end else if (bus.Enable) begin
                    w_rd = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage array; contents come from the sweep, never from reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Read stage p1: registered read data holds between reads, strobe lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= w_rd;
            if (w_rd) begin
                r_data_p1 <= w_in_range ? r_mem[bus.Address_port] : '0;
            end
        end
    end

`ifdef DMEM_OUTREG_EN
    logic [DATA_W-1:0] r_data_p2;
    logic              r_vld_p2;
    logic              w_clr;

    assign w_clr = (r_state == S_RUN) && bus.Clear;

    // Output stage p2: extra register aligned with its strobe, flushed by Clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_p2 <= '0;
            r_vld_p2  <= 1'b0;
        end else if (w_clr) begin
            r_data_p2 <= '0;
            r_vld_p2  <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= r_data_p1;
            end
        end
    end

    assign bus.Output_data = r_data_p2;
    assign bus.Valid       = r_vld_p2;
`else
    assign bus.Output_data = r_data_p1;
    assign bus.Valid       = r_vld_p1;
`endif

    assign bus.Busy = (r_state == S_INIT);

endmodule

// File: tb/tb_dmem_sweep.sv
// tb_dmem_sweep: drives two dmem_sweep instances (16 words / init 00 and
// 12 words / init 5A) with identical stimulus and compares both against a
// behavioural model of the memory, plus a directed vector table.
module tb_dmem_sweep;
`ifdef DMEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NDUT = 2;
    localparam int MAXD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_sweep_if #(.DATA_W(8), .ADDR_W(4)) bus_a ();
    dmem_sweep_if #(.DATA_W(8), .ADDR_W(4)) bus_b ();

    dmem_sweep #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_VAL(8'h00)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    dmem_sweep #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'h5A)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state, one slot per instance.
    int         m_depth [NDUT];
    logic [7:0] m_init  [NDUT];
    logic [7:0] m_mem   [NDUT][MAXD];
    int         m_busy  [NDUT];
    logic [7:0] m_out   [NDUT];
    logic       m_vld   [NDUT];
    logic [7:0] m_s1d   [NDUT];
    logic       m_s1v   [NDUT];

    typedef struct packed {
        logic       en;
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
        logic       v16;
        logic [7:0] e16;
        logic       v12;
        logic [7:0] e12;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void fill(input int k);
        for (int i = 0; i < MAXD; i++) m_mem[k][i] = m_init[k];
    endfunction

    // One clock edge of the memory as seen from its ports.
    function automatic void model_step(input int k, input logic r, input logic en,
                                       input logic we, input logic [3:0] a,
                                       input logic [7:0] d, input logic clr);
        logic       rd;
        logic [7:0] res;
        logic       flush;
        rd = 1'b0; res = 8'h00; flush = 1'b0;
        if (r) begin
            m_busy[k] = m_depth[k];
            fill(k);
            m_out[k] = 8'h00; m_vld[k] = 1'b0;
            m_s1d[k] = 8'h00; m_s1v[k] = 1'b0;
            return;
        end
        if (m_busy[k] > 0) begin
            m_busy[k]--;
        end else if (clr) begin
            m_busy[k] = m_depth[k];
            fill(k);
            flush = 1'b1;
        end else if (en && we) begin
            if (int'(a) < m_depth[k]) m_mem[k][a] = d;
        end else if (en) begin
            rd  = 1'b1;
            res = (int'(a) < m_depth[k]) ? m_mem[k][a] : 8'h00;
        end
        if (LAT == 1) begin
            m_vld[k] = rd;
            if (rd) m_out[k] = res;
        end else begin
            if (flush) begin
                m_out[k] = 8'h00; m_vld[k] = 1'b0;
            end else begin
                m_vld[k] = m_s1v[k];
                if (m_s1v[k]) m_out[k] = m_s1d[k];
            end
            m_s1v[k] = rd; m_s1d[k] = res;
        end
    endfunction

    task automatic drive(input logic en, input logic we, input logic [3:0] a,
                         input logic [7:0] d, input logic clr);
        bus_a.Enable = en; bus_a.Write_en = we; bus_a.Address_port = a;
        bus_a.Input_data = d; bus_a.Clear = clr;
        bus_b.Enable = en; bus_b.Write_en = we; bus_b.Address_port = a;
        bus_b.Input_data = d; bus_b.Clear = clr;
    endtask

    task automatic compare_all();
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("d%0d busy", m_depth[k]),
                  (k == 0) ? int'(bus_a.Busy) : int'(bus_b.Busy), int'(m_busy[k] != 0));
            check($sformatf("d%0d valid", m_depth[k]),
                  (k == 0) ? int'(bus_a.Valid) : int'(bus_b.Valid), int'(m_vld[k]));
            check($sformatf("d%0d data", m_depth[k]),
                  (k == 0) ? int'(bus_a.Output_data) : int'(bus_b.Output_data), int'(m_out[k]));
        end
    endtask

    task automatic tick(input logic r, input logic en, input logic we, input logic [3:0] a,
                        input logic [7:0] d, input logic clr);
        rst = r;
        drive(en, we, a, d, clr);
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) model_step(k, r, en, we, a, d, clr);
        #1;
        compare_all();
    endtask

    // Tick until both instances leave the sweep; optionally poke a write
    // (and later a Clear) while Busy to show they are ignored.
    task automatic wait_sweep(input string tag, input int poke_at);
        int n_a;
        int n_b;
        n_a = 0; n_b = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, (i == poke_at), 1'b1, 4'h3, 8'h55, (poke_at > 0) && (i == poke_at + 2));
            if (n_a == 0 && !bus_a.Busy) n_a = i;
            if (n_b == 0 && !bus_b.Busy) n_b = i;
            if (n_a != 0 && n_b != 0) break;
        end
        check({tag, " sweep cycles d16"}, n_a, 16);
        check({tag, " sweep cycles d12"}, n_b, 12);
    endtask

    task automatic add(input logic en, input logic we, input logic [3:0] a, input logic [7:0] d,
                       input logic v16, input logic [7:0] e16, input logic v12, input logic [7:0] e12);
        vec_t v;
        v.en = en; v.we = we; v.a = a; v.d = d;
        v.v16 = v16; v.e16 = e16; v.v12 = v12; v.e12 = e12;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        m_depth[0] = 16; m_init[0] = 8'h00;
        m_depth[1] = 12; m_init[1] = 8'h5A;

        // Reset held two cycles, then the sweep with a write and Clear poked mid-sweep.
        tick(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        wait_sweep("reset", 5);

        // Read every address once after the sweep.
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
        for (int i = 0; i < LAT; i++) tick(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);

        // Directed table: en we addr data | d16 valid/data | d12 valid/data
        add(1, 1, 4'h0, 8'hAB, 0, 8'h00, 0, 8'h00);
        add(1, 1, 4'h1, 8'h90, 0, 8'h00, 0, 8'h00);
        add(1, 1, 4'h5, 8'hFF, 0, 8'h00, 0, 8'h00);
        add(1, 1, 4'h8, 8'h12, 0, 8'h00, 0, 8'h00);
        add(1, 1, 4'hA, 8'h34, 0, 8'h00, 0, 8'h00);
        add(1, 1, 4'hF, 8'h75, 0, 8'h00, 0, 8'h00);
        add(1, 1, 4'hB, 8'h64, 0, 8'h00, 0, 8'h00);
        add(1, 1, 4'h9, 8'hFE, 0, 8'h00, 0, 8'h00);
        add(1, 0, 4'hA, 8'h00, 1, 8'h34, 1, 8'h34);
        add(1, 0, 4'h2, 8'h00, 1, 8'h00, 1, 8'h5A);
        add(1, 0, 4'hF, 8'h00, 1, 8'h75, 1, 8'h00);
        add(1, 0, 4'hC, 8'h00, 1, 8'h00, 1, 8'h00);
        add(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);
        add(1, 0, 4'h9, 8'h00, 1, 8'hFE, 1, 8'hFE);
        add(1, 0, 4'h1, 8'h00, 1, 8'h90, 1, 8'h90);
        add(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);
        add(1, 0, 4'h3, 8'h00, 1, 8'h00, 1, 8'h5A);
        add(1, 1, 4'hD, 8'h77, 0, 8'h00, 0, 8'h00);
        add(1, 0, 4'hD, 8'h00, 1, 8'h77, 1, 8'h00);
        add(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);
        add(1, 0, 4'h0, 8'h00, 1, 8'hAB, 1, 8'hAB);
        add(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);
        add(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);
        add(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            tick(1'b0, tbl[i].en, tbl[i].we, tbl[i].a, tbl[i].d, 1'b0);
            j = i - (LAT - 1);
            if (j >= 0) begin
                check($sformatf("tbl[%0d] d16 valid", j), int'(bus_a.Valid), int'(tbl[j].v16));
                check($sformatf("tbl[%0d] d12 valid", j), int'(bus_b.Valid), int'(tbl[j].v12));
                if (tbl[j].v16) check($sformatf("tbl[%0d] d16 data", j), int'(bus_a.Output_data), int'(tbl[j].e16));
                if (tbl[j].v12) check($sformatf("tbl[%0d] d12 data", j), int'(bus_b.Output_data), int'(tbl[j].e12));
            end
        end
        check("hold AB d16", int'(bus_a.Output_data), 8'hAB);
        check("hold valid d16", int'(bus_a.Valid), 0);

        // Asynchronous reset takes effect before the next clock edge.
        rst = 1'b1;
        #2;
        check("async rst busy d16", int'(bus_a.Busy), 1);
        check("async rst data d16", int'(bus_a.Output_data), 0);
        check("async rst data d12", int'(bus_b.Output_data), 0);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);

        // Reset again at sweep cycle 8: the sweep restarts in full.
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        wait_sweep("rst mid", 0);

        // Clear together with a write: the write is dropped, memory re-initialised.
        tick(1'b0, 1'b1, 1'b1, 4'h5, 8'hFF, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 4'h5, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 4'h6, 8'h11, 1'b1);
        wait_sweep("clear", 0);
        tick(1'b0, 1'b1, 1'b0, 4'h5, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 4'h6, 8'h00, 1'b0);
        for (int i = 0; i < LAT; i++) tick(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);

        // Randomised traffic with occasional Clear and reset.
        for (int i = 0; i < 500; i++) begin
            tick(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 8'($urandom),
                 ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_sweep.md
Name: dmem_sweep

Overview:
Parametrised single-port synchronous data memory for the 12-bit microcontroller. It generalises the fixed 16x8 data memory in width and depth, and adds registered reads with a valid strobe. A hardware initialisation sweep FSM zeroes or presets every word after reset or on a Clear request. It sits between the core's load/store path and the data address bus.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 4, address width in bits
DEPTH, 16, number of implemented words; 1 <= DEPTH <= 2**ADDR_W
INIT_VAL, 0, value written to every word by the init sweep (DATA_W bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
Enable  input  1  access request qualifier
Write_en  input  1  1 = write, 0 = read (when Enable=1)
Address_port  input  ADDR_W  word address
Input_data  input  DATA_W  write data
Clear  input  1  request a re-initialisation sweep
Output_data  output  DATA_W  registered read data
Valid  output  1  Output_data updated by a read this cycle
Busy  output  1  init sweep in progress; user accesses ignored

Behaviour:
- Reset (async, active-high): Output_data=0, Valid=0, Busy=1, state=INIT, sweep counter=0. Memory contents are not reset directly; the sweep initialises them.
- States: INIT, RUN.
- INIT: each cycle write INIT_VAL to mem[cnt], then cnt++.
  - The cycle cnt==DEPTH-1 is written -> next state RUN, Busy=0 from the following cycle.
  - The sweep lasts exactly DEPTH cycles after rst deassertion.
- In INIT: Enable/Write_en/Clear ignored (writes dropped, no read), Valid=0, Output_data holds.
- RUN, Enable=1, Write_en=1: mem[Address_port] <= Input_data at the edge. Valid=0, Output_data holds.
- RUN, Enable=1, Write_en=0: Output_data <= mem[Address_port]. Read latency 1 cycle; Valid=1 for exactly that cycle.
- RUN, Enable=0: no access, Valid=0, Output_data holds last value.
- Back-to-back reads each produce a Valid pulse; Valid stays high continuously for consecutive reads.
- Read of an address written in the immediately preceding cycle returns the new data.
- Clear=1 in RUN: next state INIT, cnt=0, Busy=1 the next cycle. Clear beats any same-cycle access; that access is dropped and Valid=0.
- Out-of-range address (Address_port >= DEPTH): write dropped; read returns 0 with Valid=1.
- rst asserted mid-sweep or mid-access: immediate return to the reset state; the sweep restarts from address 0.

Optional Feature:
DMEM_OUTREG_EN
- Defined: an extra output pipeline register is added. Read latency becomes 2 cycles, and Valid is delayed to align with the data. Reset and Clear flush the pipeline stage (data 0, Valid 0).
- Undefined: read latency is 1 cycle as above.

Test Plan:
- Reset sweep: hold rst for 2 cycles, release -> Busy=1 for exactly 16 cycles. Then read addresses 0..F -> each returns 00 with Valid one cycle later.
- Write/read: write 0:AB, 1:90, 5:FF, 8:12, A:34, F:75, B:64, 9:FE. Then read A, 2, F, C -> 34, 00, 75, 00, each with a 1-cycle Valid pulse. Read 9 then 1 back-to-back -> FE, 90, Valid high 2 cycles.
- Access during Busy: write 3:55 in cycle 5 of the sweep; after Busy falls, read 3 -> 00.
- Clear: after writing 5:FF, pulse Clear together with write 6:11 -> Busy for 16 cycles; then read 5 -> 00 and read 6 -> 00.
- Reset mid-sweep: assert rst at sweep cycle 8 -> Busy stays high; after release, Busy high for a full 16 cycles. Enable=0 for 3 cycles after a read of AB -> Output_data holds AB, Valid=0.
- DEPTH=12, INIT_VAL=8'h5A (with and without DMEM_OUTREG_EN): sweep takes 12 cycles; read 3 -> 5A; write D:77 then read D -> 00 with Valid. With the macro, latency is 2 cycles.
